// File: rtl/mbox_sbus_arb_if.sv
// Request/SBUS bundle for mbox_sbus_arb: requester side, memory side and error pulses.
// Address-parity signals exist only when MBOX_ADR_PAR_EN is defined.
interface mbox_sbus_arb_if;
   logic [0:2]        req;
   logic [0:2]        wr;
   logic [0:2][14:35] pa;
   logic [0:2][0:35]  wdata;
   logic [0:2]        done;
   logic              err;
   logic [0:35]       rdata;
   logic              sbus_start;
   logic              sbus_wr;
   logic [14:35]      sbus_adr;
   logic [0:35]       sbus_data_out;
   logic              sbus_ack;
   logic              sbus_dvalid;
   logic [0:35]       sbus_data_in;
   logic              sbus_dpar;
   logic              sbus_err_in;
   logic              nxm_err;
   logic              mb_par_err;
   logic              sbus_err;
   logic              adr_par_err;
`ifdef MBOX_ADR_PAR_EN
   logic              sbus_apar;
   logic              sbus_apar_bad;

   modport slave (
      input  req, wr, pa, wdata, sbus_ack, sbus_dvalid, sbus_data_in, sbus_dpar,
             sbus_err_in, sbus_apar_bad,
      output done, err, rdata, sbus_start, sbus_wr, sbus_adr, sbus_data_out,
             nxm_err, mb_par_err, sbus_err, adr_par_err, sbus_apar
   );
   modport master (
      output req, wr, pa, wdata, sbus_ack, sbus_dvalid, sbus_data_in, sbus_dpar,
             sbus_err_in, sbus_apar_bad,
      input  done, err, rdata, sbus_start, sbus_wr, sbus_adr, sbus_data_out,
             nxm_err, mb_par_err, sbus_err, adr_par_err, sbus_apar
   );
`else
   modport slave (
      input  req, wr, pa, wdata, sbus_ack, sbus_dvalid, sbus_data_in, sbus_dpar,
             sbus_err_in,
      output done, err, rdata, sbus_start, sbus_wr, sbus_adr, sbus_data_out,
             nxm_err, mb_par_err, sbus_err, adr_par_err
   );
   modport master (
      output req, wr, pa, wdata, sbus_ack, sbus_dvalid, sbus_data_in, sbus_dpar,
             sbus_err_in,
      input  done, err, rdata, sbus_start, sbus_wr, sbus_adr, sbus_data_out,
             nxm_err, mb_par_err, sbus_err, adr_par_err
   );
`endif
endinterface

// File: rtl/mbox_sbus_arb.sv
// MBOX SBUS arbiter: CHAN > EBOX > CCA (with starvation override), sequences one SBUS cycle at a time
// and reports NXM/parity/SBUS errors. Define MBOX_ADR_PAR_EN to add address-parity generation/checking.
module mbox_sbus_arb #(
   parameter int NXM_TIMEOUT = 64,
   parameter int CCA_STARVE  = 8
) (
   input logic             i_clk,
   input logic             i_crobar,
   mbox_sbus_arb_if.slave  io_bus
);
   localparam int TW = (NXM_TIMEOUT > 2) ? $clog2(NXM_TIMEOUT) : 1;
   localparam int CW = $clog2(CCA_STARVE + 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;

   state_t        r_state;
   logic [1:0]    r_owner;
   logic          r_wr;
   logic [14:35]  r_adr;
   logic [0:35]   r_wdata;
   logic          r_start;
   logic [0:2]    r_done;
   logic          r_err;
   logic [0:35]   r_rdata;
   logic          r_nxm;
   logic          r_mbpar;
   logic          r_serr;
   logic [TW-1:0] r_tmo;
   logic [CW-1:0] r_cca_loss;
`ifdef MBOX_ADR_PAR_EN
   logic          r_apar;
   logic          r_apar_err;
`endif

   logic [1:0]    w_gnt_idx;
   logic          w_sel_wr;
   logic [14:35]  w_sel_pa;
   logic [0:35]   w_sel_wdata;
   logic [0:2]    w_owner_oh;
   logic          w_arb_ok;
   logic          w_cca_forced;
   logic          w_busy;
   logic          w_apar_bad;
   logic          w_serr;
   logic          w_apar_abort;
   logic          w_ack_ok;
   logic          w_rd_done;
   logic          w_nxm;
   logic          w_abort;
   logic          w_par_bad;

`ifdef MBOX_ADR_PAR_EN
   assign w_apar_bad = io_bus.sbus_apar_bad;
`else
   assign w_apar_bad = 1'b0;
`endif

   // Arbitration is suppressed while DONE is visible so the finishing requester can drop REQ.
   assign w_arb_ok     = (r_state == S_IDLE) && (r_done == 3'b000);
   assign w_cca_forced = (r_cca_loss == CW'(CCA_STARVE));
   assign w_busy       = (r_state == S_ADDR) || (r_state == S_WAIT);
   assign w_par_bad    = ~(^{io_bus.sbus_data_in, io_bus.sbus_dpar});

   // SBUS_ERR_IN outranks ACK/DVALID and the timeout; a real ACK/DVALID outranks the timeout.
   assign w_serr       = w_busy && io_bus.sbus_err_in;
   assign w_apar_abort = (r_state == S_ADDR) && io_bus.sbus_ack && !io_bus.sbus_err_in && w_apar_bad;
   assign w_ack_ok     = (r_state == S_ADDR) && io_bus.sbus_ack && !io_bus.sbus_err_in && !w_apar_bad;
   assign w_rd_done    = (r_state == S_WAIT) && io_bus.sbus_dvalid && !io_bus.sbus_err_in;
   assign w_nxm        = w_busy && !io_bus.sbus_err_in
                         && !((r_state == S_ADDR) && io_bus.sbus_ack)
                         && !((r_state == S_WAIT) && io_bus.sbus_dvalid)
                         && (r_tmo == TW'(NXM_TIMEOUT - 1));
   assign w_abort      = w_serr || w_apar_abort || w_nxm;

   always_comb begin
      w_gnt_idx = 2'd1;
      if (io_bus.req[0])
         w_gnt_idx = 2'd0;
      else if (io_bus.req[2] && (w_cca_forced || !io_bus.req[1]))
         w_gnt_idx = 2'd2;

      w_sel_wr    = io_bus.wr[1];
      w_sel_pa    = io_bus.pa[1];
      w_sel_wdata = io_bus.wdata[1];
      case (w_gnt_idx)
         2'd0: begin
            w_sel_wr    = io_bus.wr[0];
            w_sel_pa    = io_bus.pa[0];
            w_sel_wdata = io_bus.wdata[0];
         end
         2'd2: begin
            w_sel_wr    = io_bus.wr[2];
            w_sel_pa    = io_bus.pa[2];
            w_sel_wdata = io_bus.wdata[2];
         end
         default: ;
      endcase

      w_owner_oh = 3'b000;
      case (r_owner)
         2'd0:    w_owner_oh = 3'b100;
         2'd1:    w_owner_oh = 3'b010;
         2'd2:    w_owner_oh = 3'b001;
         default: w_owner_oh = 3'b000;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_crobar) begin
      if (i_crobar) begin
         r_state    <= S_IDLE;
         r_owner    <= 2'd0;
         r_wr       <= 1'b0;
         r_adr      <= '0;
         r_wdata    <= '0;
         r_start    <= 1'b0;
         r_done     <= 3'b000;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_nxm      <= 1'b0;
         r_mbpar    <= 1'b0;
         r_serr     <= 1'b0;
         r_tmo      <= '0;
         r_cca_loss <= '0;
`ifdef MBOX_ADR_PAR_EN
         r_apar     <= 1'b0;
         r_apar_err <= 1'b0;
`endif
      end else begin
         r_done  <= 3'b000;
         r_err   <= 1'b0;
         r_nxm   <= 1'b0;
         r_mbpar <= 1'b0;
         r_serr  <= 1'b0;
`ifdef MBOX_ADR_PAR_EN
         r_apar_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_arb_ok) begin
                  if (!io_bus.req[2])
                     r_cca_loss <= '0;
                  if (io_bus.req != 3'b000) begin
                     r_owner <= w_gnt_idx;
                     r_wr    <= w_sel_wr;
                     r_adr   <= w_sel_pa;
                     r_wdata <= w_sel_wdata;
`ifdef MBOX_ADR_PAR_EN
                     r_apar  <= ~^w_sel_pa;
`endif
                     r_start <= 1'b1;
                     r_tmo   <= '0;
                     r_state <= S_ADDR;
                     if (io_bus.req[2]) begin
                        if (w_gnt_idx == 2'd2)
                           r_cca_loss <= '0;
                        else if (!w_cca_forced)
                           r_cca_loss <= r_cca_loss + CW'(1);
                     end
                  end
               end
            end
            S_ADDR, S_WAIT: begin
               r_tmo <= r_tmo + TW'(1);
               if (w_abort) begin
                  r_done  <= w_owner_oh;
                  r_err   <= 1'b1;
                  r_start <= 1'b0;
                  r_state <= S_IDLE;
                  r_serr  <= w_serr;
                  r_nxm   <= w_nxm;
`ifdef MBOX_ADR_PAR_EN
                  r_apar_err <= w_apar_abort;
`endif
                  if (!r_wr)
                     r_rdata <= '0;
               end else if (w_ack_ok) begin
                  r_start <= 1'b0;
                  if (r_wr) begin
                     r_done  <= w_owner_oh;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else if (w_rd_done) begin
                  r_done  <= w_owner_oh;
                  r_err   <= w_par_bad;
                  r_mbpar <= w_par_bad;
                  r_rdata <= io_bus.sbus_data_in;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.done          = r_done;
   assign io_bus.err           = r_err;
   assign io_bus.rdata         = r_rdata;
   assign io_bus.sbus_start    = r_start;
   assign io_bus.sbus_wr       = r_wr;
   assign io_bus.sbus_adr      = r_adr;
   assign io_bus.sbus_data_out = r_wdata;
   assign io_bus.nxm_err       = r_nxm;
   assign io_bus.mb_par_err    = r_mbpar;
   assign io_bus.sbus_err      = r_serr;
`ifdef MBOX_ADR_PAR_EN
   assign io_bus.sbus_apar     = r_apar;
   assign io_bus.adr_par_err   = r_apar_err;
`else
   assign io_bus.adr_par_err   = 1'b0;
`endif
endmodule
